// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the main_memory port arbiter.
//   ADDR_W / DATA_W     : memory-side address and data widths
//   MEM_DEPTH_DEFAULT   : default word depth of main_memory
//   LANE_IDX_W          : lane index width, enough for up to 8 lanes
//   data_t / addr_t     : data and address words
//   pend_rd_t           : read in flight between grant and return
// -----------------------------------------------------------------------------
package mem_arb_pkg;
    localparam int ADDR_W            = 32;
    localparam int DATA_W            = 32;
    localparam int MEM_DEPTH_DEFAULT = 256;
    localparam int LANE_IDX_W        = 3;

    typedef logic [DATA_W-1:0]     data_t;
    typedef logic [ADDR_W-1:0]     addr_t;
    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    // One read in flight. 'oor' forces a zero return.
    // 'bypass' substitutes the same-cycle write data for the memory output.
    typedef struct packed {
        logic      valid;
        lane_idx_t idx;
        logic      oor;
        logic      bypass;
        data_t     bypass_data;
    } pend_rd_t;
endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// One-hot round-robin picker. The search starts at i_ptr and wraps modulo N.
// The first requester found wins.
// Ports:
//   i_req      : request vector
//   i_ptr      : lane that has the highest priority this cycle
//   o_gnt      : one-hot grant (all zero when there is no request)
//   o_any      : a grant was made
//   o_idx      : index of the winner (valid when o_any)
//   o_next_ptr : (winner+1) mod N on a grant, otherwise i_ptr
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic             o_any,
    output logic [PTR_W-1:0] o_idx,
    output logic [PTR_W-1:0] o_next_ptr
);
    int w_cand;

    always_comb begin
        o_gnt      = '0;
        o_any      = 1'b0;
        o_idx      = i_ptr;
        o_next_ptr = i_ptr;
        w_cand     = 0;
        for (int k = 0; k < N; k++) begin
            w_cand = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = PTR_W'(w_cand);
                o_next_ptr    = PTR_W'((w_cand + 1) % N);
            end
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one main_memory between NUM_LANES load/store lanes. The memory has
// one write port and one registered read port. Each cycle the arbiter grants
// at most one read and at most one write. Reads and writes use independent
// round-robin pointers. Read data returns one cycle after the grant and is
// tagged with the lane that requested it.
//
// Request/grant: lane_req[i] is held until lane_gnt[i] is high in the same
// cycle. The request is consumed at that clock edge. There is no backpressure
// on the read return.
//
// Optional feature: define MEM_ARB_RAW_BYPASS_EN to enable read-after-write
// bypass. A read and a write to the same in-range address in one cycle then
// return the new data. Without it, the read returns the old memory contents.
//
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   lane_req/we       : per-lane request valid and direction (1 = write)
//   lane_addr/wdata   : per-lane word address / write data, 32 bits per lane
//   lane_gnt          : combinational grant
//   lane_err          : pulse one cycle after an out-of-range grant
//   rd_valid, rd_data : one-hot read return strobe and data
//   mem_*             : main_memory write/read port signals
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_LANES-1:0]        lane_req,
    input  logic [NUM_LANES-1:0]        lane_we,
    input  logic [NUM_LANES*ADDR_W-1:0] lane_addr,
    input  logic [NUM_LANES*DATA_W-1:0] lane_wdata,
    output logic [NUM_LANES-1:0]        lane_gnt,
    output logic [NUM_LANES-1:0]        lane_err,
    output logic [NUM_LANES-1:0]        rd_valid,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        mem_wr_en,
    output logic [ADDR_W-1:0]           mem_wr_addr,
    output logic [DATA_W-1:0]           mem_data_in,
    output logic [DATA_W-1:0]           mem_wr_data,
    output logic                        mem_rd_en,
    output logic [ADDR_W-1:0]           mem_rd_addr,
    input  logic [DATA_W-1:0]           mem_data_out
);
    localparam int PTR_W = $clog2(NUM_LANES);

    logic [PTR_W-1:0]     r_rd_ptr, r_wr_ptr;
    pend_rd_t             r_pend;
    logic [NUM_LANES-1:0] r_lane_err;

    logic [NUM_LANES-1:0] w_rd_req, w_wr_req, w_rd_gnt, w_wr_gnt;
    logic                 w_rd_any, w_wr_any;
    logic [PTR_W-1:0]     w_rd_idx, w_wr_idx, w_rd_next, w_wr_next;
    addr_t                w_rd_addr, w_wr_addr;
    data_t                w_wr_data;
    logic                 w_rd_in_range, w_wr_in_range;
    logic                 w_rd_mem, w_wr_mem;
    logic                 w_bypass;

    assign w_rd_req = lane_req & ~lane_we;
    assign w_wr_req = lane_req &  lane_we;

    rr_picker #(.N(NUM_LANES), .PTR_W(PTR_W)) u_rd_pick (
        .i_req      (w_rd_req),
        .i_ptr      (r_rd_ptr),
        .o_gnt      (w_rd_gnt),
        .o_any      (w_rd_any),
        .o_idx      (w_rd_idx),
        .o_next_ptr (w_rd_next)
    );

    rr_picker #(.N(NUM_LANES), .PTR_W(PTR_W)) u_wr_pick (
        .i_req      (w_wr_req),
        .i_ptr      (r_wr_ptr),
        .o_gnt      (w_wr_gnt),
        .o_any      (w_wr_any),
        .o_idx      (w_wr_idx),
        .o_next_ptr (w_wr_next)
    );

    assign w_rd_addr = lane_addr[int'(w_rd_idx)*ADDR_W +: ADDR_W];
    assign w_wr_addr = lane_addr[int'(w_wr_idx)*ADDR_W +: ADDR_W];
    assign w_wr_data = lane_wdata[int'(w_wr_idx)*DATA_W +: DATA_W];

    assign w_rd_in_range = (w_rd_addr < addr_t'(MEM_DEPTH));
    assign w_wr_in_range = (w_wr_addr < addr_t'(MEM_DEPTH));

    // Out-of-range requests are still granted, which consumes them. They never
    // touch the memory.
    assign w_rd_mem = rst_n & w_rd_any & w_rd_in_range;
    assign w_wr_mem = rst_n & w_wr_any & w_wr_in_range;

`ifdef MEM_ARB_RAW_BYPASS_EN
    assign w_bypass = w_rd_mem & w_wr_mem & (w_rd_addr == w_wr_addr);
`else
    assign w_bypass = 1'b0;
`endif

    assign lane_gnt    = rst_n ? (w_rd_gnt | w_wr_gnt) : '0;

    assign mem_wr_en   = w_wr_mem;
    assign mem_wr_addr = w_wr_mem ? w_wr_addr : '0;
    assign mem_data_in = w_wr_mem ? w_wr_data : '0;
    assign mem_wr_data = w_wr_mem ? w_wr_data : '0;
    assign mem_rd_en   = w_rd_mem;
    assign mem_rd_addr = w_rd_mem ? w_rd_addr : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_pend     <= '0;
            r_lane_err <= '0;
        end else begin
            // The picker's next pointer equals the current one when nothing is granted.
            r_rd_ptr           <= w_rd_next;
            r_wr_ptr           <= w_wr_next;
            r_pend.valid       <= w_rd_any;
            r_pend.idx         <= lane_idx_t'(w_rd_idx);
            r_pend.oor         <= w_rd_any & ~w_rd_in_range;
            r_pend.bypass      <= w_bypass;
            r_pend.bypass_data <= w_bypass ? w_wr_data : '0;
            r_lane_err         <= ((w_rd_any && !w_rd_in_range) ? w_rd_gnt : '0)
                                | ((w_wr_any && !w_wr_in_range) ? w_wr_gnt : '0);
        end
    end

    // mem_data_out arrives in the cycle after the grant, so the data mux is
    // combinational on the registered pending entry. Gating with rst_n drops a
    // read that was granted just before reset asserted.
    assign rd_valid = (rst_n && r_pend.valid) ? (NUM_LANES'(1) << r_pend.idx) : '0;
    assign lane_err = rst_n ? r_lane_err : '0;
    assign rd_data  = (!rst_n || !r_pend.valid || r_pend.oor) ? '0
                    : (r_pend.bypass ? r_pend.bypass_data : mem_data_out);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with 4 lanes and a behavioural
// main_memory. The memory has a registered read and read-before-write
// behaviour. Expected values are computed by hand from the request sequence.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    localparam int NL = 4;

    logic            clk;
    logic            rst_n;
    logic [NL-1:0]   lane_req, lane_we, lane_gnt, lane_err, rd_valid;
    logic [NL*32-1:0] lane_addr, lane_wdata;
    logic [31:0]     rd_data;
    logic            mem_wr_en, mem_rd_en;
    logic [31:0]     mem_wr_addr, mem_data_in, mem_wr_data, mem_rd_addr, mem_data_out;

    logic [31:0]     mem_arr [256];
    logic [31:0]     mem_q;

    int chk_cnt = 0;
    int err_cnt = 0;

    mem_port_arbiter #(.NUM_LANES(NL), .MEM_DEPTH(256)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lane_req     (lane_req),
        .lane_we      (lane_we),
        .lane_addr    (lane_addr),
        .lane_wdata   (lane_wdata),
        .lane_gnt     (lane_gnt),
        .lane_err     (lane_err),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_data_in  (mem_data_in),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_data_out (mem_data_out)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural main_memory: registered read, read returns the old value
    always @(posedge clk) begin
        if (mem_rd_en) mem_q <= mem_arr[mem_rd_addr[7:0]];
        if (mem_wr_en) mem_arr[mem_wr_addr[7:0]] <= mem_data_in;
    end
    assign mem_data_out = mem_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic clear_lanes();
        lane_req   = '0;
        lane_we    = '0;
        lane_addr  = '0;
        lane_wdata = '0;
    endtask

    task automatic set_lane(input int i, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
        lane_req[i]             = 1'b1;
        lane_we[i]              = we;
        lane_addr[i*32 +: 32]   = addr;
        lane_wdata[i*32 +: 32]  = wdata;
    endtask

    // advance one edge; the outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_comb(input string tag, input logic [3:0] gnt, input logic wen,
                            input logic ren);
        #1;
        check({tag, ".gnt"},  32'(lane_gnt),  32'(gnt));
        check({tag, ".wen"},  32'(mem_wr_en), 32'(wen));
        check({tag, ".ren"},  32'(mem_rd_en), 32'(ren));
    endtask

    task automatic chk_ret(input string tag, input logic [3:0] vld, input logic [31:0] data,
                           input logic [3:0] err);
        check({tag, ".rd_valid"}, 32'(rd_valid), 32'(vld));
        check({tag, ".rd_data"},  rd_data,       data);
        check({tag, ".lane_err"}, 32'(lane_err), 32'(err));
    endtask

    task automatic chk_ptrs(input string tag, input int rp, input int wp);
        check({tag, ".rd_ptr"}, 32'(dut.r_rd_ptr), 32'(rp));
        check({tag, ".wr_ptr"}, 32'(dut.r_wr_ptr), 32'(wp));
    endtask

    logic [31:0] hazard_exp;

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = '0;
        for (int i = 0; i < 4; i++) mem_arr[20+i] = 32'hA000_0000 + i;
        mem_q = '0;

        // reset: requests are present but nothing may be granted
        rst_n = 1'b0;
        clear_lanes();
        set_lane(0, 1'b1, 32'd1, 32'h5);
        set_lane(1, 1'b1, 32'd2, 32'h6);
        set_lane(2, 1'b0, 32'd1, 32'h0);
        set_lane(3, 1'b0, 32'd2, 32'h0);
        chk_comb("reset", 4'b0000, 1'b0, 1'b0);
        tick();
        tick();
        chk_ret("reset", 4'b0000, 32'h0, 4'b0000);
        chk_ptrs("reset", 0, 0);
        clear_lanes();
        rst_n = 1'b1;

        // all four lanes hold reads: grants rotate 0,1,2,3
        for (int i = 0; i < 4; i++) set_lane(i, 1'b0, 32'(20 + i), 32'h0);
        for (int c = 0; c < 4; c++) begin
            chk_comb("rr_rd", 4'(1 << c), 1'b0, 1'b1);
            check("rr_rd.addr", mem_rd_addr, 32'(20 + c));
            tick();
            chk_ret("rr_rd.ret", 4'(1 << c), 32'hA000_0000 + 32'(c), 4'b0000);
        end
        clear_lanes();
        chk_ptrs("rr_rd", 0, 0);

        // lane1 writes 0xDEADBEEF to address 5
        set_lane(1, 1'b1, 32'd5, 32'hDEAD_BEEF);
        chk_comb("wr5", 4'b0010, 1'b1, 1'b0);
        check("wr5.addr",  mem_wr_addr, 32'd5);
        check("wr5.din",   mem_data_in, 32'hDEAD_BEEF);
        check("wr5.wdata", mem_wr_data, 32'hDEAD_BEEF);
        tick();
        clear_lanes();

        // lane1 reads address 5
        set_lane(1, 1'b0, 32'd5, 32'h0);
        chk_comb("rd5", 4'b0010, 1'b0, 1'b1);
        tick();
        clear_lanes();
        chk_ret("rd5", 4'b0010, 32'hDEAD_BEEF, 4'b0000);
        chk_ptrs("rd5", 2, 2);

        // lane0 writes to address 7 while lane2 reads address 9
        set_lane(0, 1'b1, 32'd7, 32'h11);
        set_lane(2, 1'b0, 32'd9, 32'h0);
        chk_comb("rw", 4'b0101, 1'b1, 1'b1);
        tick();
        clear_lanes();
        chk_ret("rw", 4'b0100, 32'h0, 4'b0000);
        chk_ptrs("rw", 3, 1);

        // write and read to the same address in the same cycle
        set_lane(0, 1'b1, 32'd3, 32'h22);
        set_lane(1, 1'b0, 32'd3, 32'h0);
        chk_comb("haz", 4'b0011, 1'b1, 1'b1);
        tick();
        clear_lanes();
`ifdef MEM_ARB_RAW_BYPASS_EN
        hazard_exp = 32'h22;
`else
        hazard_exp = 32'h0;
`endif
        chk_ret("haz", 4'b0010, hazard_exp, 4'b0000);
        chk_ptrs("haz", 2, 1);

        // out-of-range read from lane3
        set_lane(3, 1'b0, 32'd300, 32'h0);
        chk_comb("oor_rd", 4'b1000, 1'b0, 1'b0);
        check("oor_rd.addr", mem_rd_addr, 32'h0);
        tick();
        clear_lanes();
        chk_ret("oor_rd", 4'b1000, 32'h0, 4'b1000);

        // out-of-range write from lane2 (first address past the end)
        set_lane(2, 1'b1, 32'd256, 32'h55);
        chk_comb("oor_wr", 4'b0100, 1'b0, 1'b0);
        tick();
        clear_lanes();
        chk_ret("oor_wr", 4'b0000, 32'h0, 4'b0100);
        chk_ptrs("oor", 0, 3);

        // idle cycle
        chk_comb("idle", 4'b0000, 1'b0, 1'b0);
        tick();
        chk_ret("idle", 4'b0000, 32'h0, 4'b0000);
        chk_ptrs("idle", 0, 3);

        // reset while a read is in flight
        set_lane(2, 1'b0, 32'd20, 32'h0);
        chk_comb("rst_mid", 4'b0100, 1'b0, 1'b1);
        tick();
        rst_n = 1'b0;
        chk_comb("rst_mid.hold", 4'b0000, 1'b0, 1'b0);
        check("rst_mid.rd_valid", 32'(rd_valid), 32'h0);
        tick();
        check("rst_mid.rd_valid2", 32'(rd_valid), 32'h0);
        chk_ptrs("rst_mid", 0, 0);
        clear_lanes();
        rst_n = 1'b1;

        // normal operation after reset
        set_lane(1, 1'b0, 32'd5, 32'h0);
        chk_comb("post_rst", 4'b0010, 1'b0, 1'b1);
        tick();
        clear_lanes();
        chk_ret("post_rst", 4'b0010, 32'hDEAD_BEEF, 4'b0000);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
